// File: rtl/bmu_result_collector.sv
// Captures BMU results one cycle after issue, tags them and queues them for writeback.
// Issue credit counts the in-flight capture so a push never meets a full FIFO.
module bmu_result_collector #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issueValid,
  input  logic [TAG_W-1:0] issueTag,
  input  logic [31:0]      bmuResult,
  input  logic             bmuError,
  output logic             issueStall,
  output logic             outValid,
  input  logic             outReady,
  output logic [31:0]      outResult,
  output logic [TAG_W-1:0] outTag,
  output logic             outError,
  output logic [15:0]      errCount,
  output logic             dropSticky,
  input  logic             clrStats
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW+1:0] OCC_FULL = (AW+2)'(DEPTH);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0]      res;
    logic             err;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           head;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             pend_valid_q, pend_valid_d;
  logic [TAG_W-1:0] pend_tag_q, pend_tag_d;
  logic [15:0]      err_cnt_q, err_cnt_d;
  logic             drop_q, drop_d;
  logic [AW+1:0]    occupancy;
  logic             stall, push, pop, drop, err_push;

  assign occupancy = {1'b0, count_q} + {{(AW+1){1'b0}}, pend_valid_q};
  assign stall     = (occupancy >= OCC_FULL);
  assign push      = pend_valid_q;
  assign pop       = (count_q != '0) & outReady;
  assign drop      = issueValid & stall;
  assign err_push  = push & bmuError;

  always_comb begin
    pend_valid_d = issueValid & ~stall;
    pend_tag_d   = pend_tag_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    err_cnt_d    = err_cnt_q;
    drop_d       = drop_q | drop;

    if (issueValid && !stall) pend_tag_d = issueTag;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase

    // A clear coinciding with an error push or a drop keeps that event.
    if (clrStats) begin
      err_cnt_d = {15'b0, err_push};
      drop_d    = drop;
    end else if (err_push && err_cnt_q != '1) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid_q <= 1'b0;
      pend_tag_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      err_cnt_q    <= '0;
      drop_q       <= 1'b0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_tag_q   <= pend_tag_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      err_cnt_q    <= err_cnt_d;
      drop_q       <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {pend_tag_q, bmuResult, bmuError};
  end

  // Head fields are forced to zero when empty so reset values hold without clearing storage.
  assign head       = mem_q[rd_ptr_q];
  assign outValid   = (count_q != '0);
  assign outResult  = outValid ? head.res : '0;
  assign outTag     = outValid ? head.tag : '0;
  assign outError   = outValid ? head.err : 1'b0;
  assign issueStall = stall;
  assign errCount   = err_cnt_q;
  assign dropSticky = drop_q;

endmodule

// File: tb/tb_bmu_result_collector.sv
// Self-checking bench for bmu_result_collector: behavioural model plus result scoreboard,
// a vector table for fill/stall/drain and directed multi-cycle sequences.
module tb_bmu_result_collector;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        issueValid;
  logic [3:0]  issueTag;
  logic [31:0] bmuResult;
  logic        bmuError;
  logic        issueStall;
  logic        outValid;
  logic        outReady;
  logic [31:0] outResult;
  logic [3:0]  outTag;
  logic        outError;
  logic [15:0] errCount;
  logic        dropSticky;
  logic        clrStats;

  bmu_result_collector #(.DEPTH(DEPTH), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .issueValid(issueValid), .issueTag(issueTag),
    .bmuResult(bmuResult), .bmuError(bmuError),
    .issueStall(issueStall),
    .outValid(outValid), .outReady(outReady),
    .outResult(outResult), .outTag(outTag), .outError(outError),
    .errCount(errCount), .dropSticky(dropSticky), .clrStats(clrStats)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  tag;
    logic [31:0] res;
    logic        err;
  } ent_t;

  typedef struct {
    logic        iv;
    logic [3:0]  tag;
    logic        rdy;
    logic        exp_valid;
    logic [3:0]  exp_tag;
    logic        exp_stall;
    logic        exp_drop;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  ent_t sb[$];

  int          mdl_cnt;
  bit          mdl_pend;
  int          mdl_err;
  bit          mdl_drop;
  logic [31:0] nres;
  logic        nerr;

  logic        o_valid, o_stall, o_err, o_drop;
  logic [3:0]  o_tag;
  logic [31:0] o_res;
  logic [15:0] o_errc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    mdl_cnt  = 0;
    mdl_pend = 0;
    mdl_err  = 0;
    mdl_drop = 0;
    nres     = '0;
    nerr     = 1'b0;
  endtask

  // One clock cycle, entered and left 1 time unit after a rising edge.
  task automatic cycle(input logic iv, input logic [3:0] tag, input logic [31:0] res,
                       input logic err, input logic rdy, input logic clr);
    bit   stall_m, accept, drop, push, pop;
    ent_t e;
    stall_m    = (mdl_cnt + (mdl_pend ? 1 : 0)) >= DEPTH;
    issueValid = iv;
    issueTag   = tag;
    outReady   = rdy;
    clrStats   = clr;
    bmuResult  = mdl_pend ? nres : $urandom;
    bmuError   = mdl_pend ? nerr : 1'($urandom);
    #4;
    o_valid = outValid;  o_tag = outTag;   o_res  = outResult; o_err = outError;
    o_stall = issueStall; o_drop = dropSticky; o_errc = errCount;
    chk("issueStall", 32'(o_stall), 32'(stall_m));
    chk("outValid", 32'(o_valid), 32'(mdl_cnt != 0));
    chk("errCount", 32'(o_errc), 32'(mdl_err));
    chk("dropSticky", 32'(o_drop), 32'(mdl_drop));
    if (o_valid && rdy) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected got tag %h expected no entry", o_tag);
      end else begin
        e = sb.pop_front();
        chk("head_tag", 32'(o_tag), 32'(e.tag));
        chk("head_result", o_res, e.res);
        chk("head_error", 32'(o_err), 32'(e.err));
      end
    end
    push   = mdl_pend;
    pop    = (mdl_cnt != 0) && rdy;
    accept = iv && !stall_m;
    drop   = iv && stall_m;
    if (clr) mdl_err = (push && nerr) ? 1 : 0;
    else if (push && nerr && mdl_err != 16'hFFFF) mdl_err++;
    mdl_drop = clr ? drop : (mdl_drop | drop);
    mdl_cnt  = mdl_cnt + (push ? 1 : 0) - (pop ? 1 : 0);
    if (accept) begin
      sb.push_back('{tag: tag, res: res, err: err});
      nres = res;
      nerr = err;
    end
    mdl_pend = accept;
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[11];

  initial begin
    // Fill to DEPTH with outReady low, drop a 5th issue, then drain in order.
    tbl[0]  = '{1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 4'd1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 4'd2, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 4'd3, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 4'd4, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 4'd0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1};
    tbl[6]  = '{1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1};
    tbl[7]  = '{1'b0, 4'd0, 1'b1, 1'b1, 4'd1, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 4'd0, 1'b1, 1'b1, 4'd2, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 4'd0, 1'b1, 1'b1, 4'd3, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1};

    rst = 1'b1;
    issueValid = 1'b0; issueTag = '0; bmuResult = '0; bmuError = 1'b0;
    outReady = 1'b0; clrStats = 1'b0;
    model_reset();
    #12;
    chk("reset_stall", 32'(issueStall), 32'd0);
    chk("reset_valid", 32'(outValid), 32'd0);
    chk("reset_result", outResult, 32'd0);
    chk("reset_tag", 32'(outTag), 32'd0);
    chk("reset_error", 32'(outError), 32'd0);
    chk("reset_errcount", 32'(errCount), 32'd0);
    chk("reset_drop", 32'(dropSticky), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single op: visible two cycles after issue, gone the cycle after the pop.
    cycle(1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0);
    chk("single_valid_n", 32'(o_valid), 32'd0);
    cycle(1'b0, 4'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    chk("single_valid_n1", 32'(o_valid), 32'd0);
    cycle(1'b0, 4'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    chk("single_valid_n2", 32'(o_valid), 32'd1);
    chk("single_result", o_res, 32'hDEADBEEF);
    chk("single_tag", 32'(o_tag), 32'd3);
    chk("single_error", 32'(o_err), 32'd0);
    cycle(1'b0, 4'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    chk("single_valid_n3", 32'(o_valid), 32'd0);

    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].iv, tbl[i].tag, 32'hA0 + 32'(tbl[i].tag), 1'b0, tbl[i].rdy, 1'b0);
      chk($sformatf("tbl%0d_valid", i), 32'(o_valid), 32'(tbl[i].exp_valid));
      chk($sformatf("tbl%0d_stall", i), 32'(o_stall), 32'(tbl[i].exp_stall));
      chk($sformatf("tbl%0d_drop", i), 32'(o_drop), 32'(tbl[i].exp_drop));
      if (tbl[i].exp_valid)
        chk($sformatf("tbl%0d_tag", i), 32'(o_tag), 32'(tbl[i].exp_tag));
    end
    cycle(1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("drop_cleared", 32'(o_drop), 32'd0);

    // Wrap with simultaneous push and pop every cycle.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 4'(i), 32'h100 + 32'(i), 1'b0, 1'b1, 1'b0);
      chk("wrap_stall", 32'(o_stall), 32'd0);
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    chk("wrap_drained", 32'(sb.size()), 32'd0);

    // Error accounting, then clear coinciding with an error push.
    for (int i = 0; i < 5; i++)
      cycle(1'b1, 4'(i + 8), 32'h200 + 32'(i), 1'((i % 2) == 0), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    chk("err_count3", 32'(o_errc), 32'd3);
    cycle(1'b1, 4'd7, 32'h300, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 4'd0, 32'd0, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 4'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    chk("err_clr_push", 32'(o_errc), 32'd1);

    // Saturation.
    for (int unsigned i = 0; i < 65537; i++)
      cycle(1'b1, 4'(i), i, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    chk("err_saturated", 32'(o_errc), 32'h0000FFFF);

    // Asynchronous reset with two buffered entries and one pending.
    cycle(1'b1, 4'd1, 32'h401, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 4'd2, 32'h402, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 4'd3, 32'h403, 1'b0, 1'b0, 1'b0);
    chk("pre_reset_valid", 32'(outValid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("areset_valid", 32'(outValid), 32'd0);
    chk("areset_stall", 32'(issueStall), 32'd0);
    chk("areset_result", outResult, 32'd0);
    chk("areset_tag", 32'(outTag), 32'd0);
    chk("areset_error", 32'(outError), 32'd0);
    chk("areset_errcount", 32'(errCount), 32'd0);
    chk("areset_drop", 32'(dropSticky), 32'd0);
    issueValid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 4'd5, 32'h55AA55AA, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 4'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 4'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    chk("post_reset_valid", 32'(o_valid), 32'd1);
    chk("post_reset_tag", 32'(o_tag), 32'd5);
    chk("post_reset_result", o_res, 32'h55AA55AA);
    cycle(1'b0, 4'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    chk("final_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
